branch_seq: RTL and testbench
=============================

# branch_seq

Synthesizable Moore sequencer that runs instruction fetch and the full conditional-branch execute sequence for the Mini SRC datapath. It drives the datapath's existing control inputs and evaluates all four branch conditions (brzr, brnz, brpl, brmi) internally from the register value on the bus. It has a start/done handshake and a parametrised memory wait. It sits between the top-level control unit and `datapath`, and replaces hand-written per-branch stepping.

## Interface
- `DATA_W`, 32: bus width used for condition evaluation.
- `MEM_WAIT`, 1: cycles `ram_read` is held before the MDR latch, legal range 1..15. Values outside this range cause an elaboration error.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `clear`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request one fetch+branch sequence; sampled only in IDLE.
- `ir_cond`  in  2  IR[20:19] as latched in IR; sampled in T3.
- `bus_in`  in  DATA_W  datapath bus; sampled in T3.
- `incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read, ram_read, Gra, e_Rout, imm_sel`  out  1 each  datapath controls.
- `ALU_op`  out  4  ALU operation.
- `BusDataSelect`  out  5  bus source select.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE.
- `taken`  out  1  registered condition result of the last sequence.

## Operation
- All outputs except `taken` are a combinational decode of the state register. Each is valid for the whole cycle of its state; anything not listed for a state is 0.
- States and their outputs:
  - IDLE: no outputs asserted.
  - T0: `BusDataSelect`=10100 (PCout), `e_MAR`, `incPC`, `e_Z`.
  - T1, held for MEM_WAIT cycles: `ram_read`, `BusDataSelect`=10011 (Zlowout).
  - T1L: `MDR_read`, `e_MDR`.
  - T2: `BusDataSelect`=10101 (MDRout), `e_IR`.
  - T3: `Gra`, `e_Rout`; the condition is evaluated.
  - T4: `BusDataSelect`=10100, `e_Y`.
  - T5: `BusDataSelect`=01100 (C offset), `imm_sel`, `ALU_op`=0011 (ADD), `e_Z`.
  - T6: `BusDataSelect`=10011; `e_PC` only if `taken`.
  - DONE: `done`.
- Transitions:
  - IDLE→T0 when `start`=1.
  - T1 self-loops on a 4-bit wait counter until MEM_WAIT cycles have elapsed, then →T1L.
  - All other states advance linearly; DONE→IDLE unconditionally.
- Condition, evaluated at the end of T3 and registered into `taken`:
  - 00 brzr: `bus_in`==0.
  - 01 brnz: `bus_in`!=0.
  - 10 brpl: `bus_in[DATA_W-1]`==0.
  - 11 brmi: `bus_in[DATA_W-1]`==1.
- `taken` holds its value until the next T3.
- `start` in any state other than IDLE is ignored. There is no queueing; a `start` asserted during DONE is lost.

## Timing
- Reset: `clear`=0 forces IDLE, wait counter 0 and `taken`=0. Every output is 0 while `clear` is low, including mid-sequence; no partial write completes after reset asserts.
- With `start` sampled high at edge k, T0 occupies cycle k+1.
- Full path: `done` is high in cycle k+8+MEM_WAIT (k+9 at the default). `busy` is high from cycle k+1 through the DONE cycle inclusive.
- `taken` updates on the edge that leaves T3 and is therefore valid from T4 onward.
- Back-to-back operation: `start` held high continuously gives one IDLE cycle between sequences.

## Configuration
- `BRANCH_SKIP_EN` defined: when the condition is false, T3→DONE directly, skipping T4–T6. Not-taken latency becomes `done` at k+5+MEM_WAIT. The taken path is unchanged.
- `BRANCH_SKIP_EN` undefined: all states always execute; on a false condition only `e_PC` is suppressed in T6.

## Test plan
- brnz, R1=0x0000_0005, PC=0, C=+4, MEM_WAIT=1 -> `taken`=1, PC=0x0000_0005 after T6 (PC+1+C), `done` at k+9.
- brnz, R1=0 -> `taken`=0, `e_PC` never asserted, PC=1 after the sequence; `done` at k+9, or k+6 with `BRANCH_SKIP_EN`.
- brmi, R1=0x8000_0000, then brpl with the same R1 -> `taken`=1, then `taken`=0; brzr with R1=0 -> `taken`=1.
- MEM_WAIT=3 -> `ram_read` high for exactly 3 cycles, `done` at k+11.
- `clear` pulled low during T5 -> all outputs 0 immediately, `taken`=0, IDLE after release, PC not modified.
- `start` pulsed during T2 and during DONE -> ignored, exactly one `done` pulse; continuous `start` -> sequences separated by one IDLE cycle.

Source files
------------

// File: rtl/branch_seq.sv
`default_nettype none
// ============================================================================
// Module   : branch_seq
// Purpose  : Moore sequencer for the Mini SRC datapath. It runs one
//            instruction fetch followed by the conditional-branch execute
//            steps, and evaluates brzr/brnz/brpl/brmi from the register value
//            on the bus. Requests use a start/done handshake, and the memory
//            read wait is set by a parameter.
// Config   : BRANCH_SKIP_EN (macro) - when defined, a false condition jumps
//            from T3 straight to DONE and skips T4..T6.
// Params   : DATA_W   - bus width used for condition evaluation
//            MEM_WAIT - cycles ram_read is held before the MDR latch (1..15)
// Ports    : clock, clear (async active-low reset)
//            start          - request a fetch+branch sequence (seen in IDLE)
//            ir_cond[1:0]   - IR[20:19], sampled in T3
//            bus_in         - datapath bus, sampled in T3
//            incPC..imm_sel, ALU_op, BusDataSelect - datapath controls
//            busy           - high in every state except IDLE
//            done           - one-cycle pulse in DONE
//            taken          - registered condition result of last sequence
// Revision : 1.0 - initial release
// ============================================================================
module branch_seq #(
    parameter int DATA_W   = 32,
    parameter int MEM_WAIT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [1:0]        ir_cond,
    input  logic [DATA_W-1:0] bus_in,
    output logic              incPC,
    output logic              e_PC,
    output logic              e_IR,
    output logic              e_Y,
    output logic              e_Z,
    output logic              e_MAR,
    output logic              e_MDR,
    output logic              MDR_read,
    output logic              ram_read,
    output logic              Gra,
    output logic              e_Rout,
    output logic              imm_sel,
    output logic [3:0]        ALU_op,
    output logic [4:0]        BusDataSelect,
    output logic              busy,
    output logic              done,
    output logic              taken
);

    generate
        if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_bad_mem_wait
            $error("branch_seq: MEM_WAIT must lie in 1..15");
        end
    endgenerate

    localparam logic [4:0] BDS_PCOUT   = 5'b10100;
    localparam logic [4:0] BDS_ZLOWOUT = 5'b10011;
    localparam logic [4:0] BDS_MDROUT  = 5'b10101;
    localparam logic [4:0] BDS_COFFSET = 5'b01100;
    localparam logic [3:0] ALU_ADD     = 4'b0011;
    // Last count value of the T1 wait loop; the loop exits after MEM_WAIT cycles.
    localparam logic [3:0] WAIT_LAST   = 4'(MEM_WAIT - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T1L  = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_T6   = 4'd8,
        S_DONE = 4'd9
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       cond_true;

    // Branch condition from the value currently driven onto the bus.
    always_comb begin
        cond_true = 1'b0;
        case (ir_cond)
            2'b00:   cond_true = ~|bus_in;             // brzr
            2'b01:   cond_true =  |bus_in;             // brnz
            2'b10:   cond_true = ~bus_in[DATA_W-1];    // brpl
            default: cond_true =  bus_in[DATA_W-1];    // brmi
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            taken    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_T0;
                    end
                end
                S_T0: begin
                    wait_cnt <= 4'd0;
                    state    <= S_T1;
                end
                S_T1: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 4'd0;
                        state    <= S_T1L;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_T1L: state <= S_T2;
                S_T2:  state <= S_T3;
                S_T3: begin
                    taken <= cond_true;
`ifdef BRANCH_SKIP_EN
                    state <= cond_true ? S_T4 : S_DONE;
`else
                    state <= S_T4;
`endif
                end
                S_T4:    state <= S_T5;
                S_T5:    state <= S_T6;
                S_T6:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the state register. Reset forces IDLE asynchronously,
    // so every control drops the moment clear goes low.
    always_comb begin
        incPC         = 1'b0;
        e_PC          = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_MAR         = 1'b0;
        e_MDR         = 1'b0;
        MDR_read      = 1'b0;
        ram_read      = 1'b0;
        Gra           = 1'b0;
        e_Rout        = 1'b0;
        imm_sel       = 1'b0;
        ALU_op        = 4'b0000;
        BusDataSelect = 5'b00000;
        done          = 1'b0;
        busy          = (state != S_IDLE);
        case (state)
            S_T0: begin
                BusDataSelect = BDS_PCOUT;
                e_MAR         = 1'b1;
                incPC         = 1'b1;
                e_Z           = 1'b1;
            end
            S_T1: begin
                ram_read      = 1'b1;
                BusDataSelect = BDS_ZLOWOUT;
            end
            S_T1L: begin
                MDR_read = 1'b1;
                e_MDR    = 1'b1;
            end
            S_T2: begin
                BusDataSelect = BDS_MDROUT;
                e_IR          = 1'b1;
            end
            S_T3: begin
                Gra    = 1'b1;
                e_Rout = 1'b1;
            end
            S_T4: begin
                BusDataSelect = BDS_PCOUT;
                e_Y           = 1'b1;
            end
            S_T5: begin
                BusDataSelect = BDS_COFFSET;
                imm_sel       = 1'b1;
                ALU_op        = ALU_ADD;
                e_Z           = 1'b1;
            end
            S_T6: begin
                BusDataSelect = BDS_ZLOWOUT;
                e_PC          = taken;   // PC is only written when the branch is taken
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_seq
// Purpose  : Self-checking bench for branch_seq. Two instances run side by
//            side (MEM_WAIT=1 and MEM_WAIT=3). A queue-based reference model
//            predicts the control word for every cycle and the taken flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_seq;

    localparam int DW = 32;
`ifdef BRANCH_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic       incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR;
        logic       MDR_read, ram_read, Gra, e_Rout, imm_sel;
        logic [3:0] alu;
        logic [4:0] bds;
        logic       busy, done;
    } ctl_t;

    typedef struct packed {
        ctl_t c;
        bit   t3;
    } ent_t;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic [1:0]    ir_cond;
    logic [DW-1:0] bus_in;
    wire ctl_t     obs_a;
    wire ctl_t     obs_b;
    logic          taken_a, taken_b;

    always #5 clock = ~clock;

    branch_seq #(.DATA_W(DW), .MEM_WAIT(1)) dut_a (
        .clock(clock), .clear(clear), .start(start), .ir_cond(ir_cond), .bus_in(bus_in),
        .incPC(obs_a.incPC), .e_PC(obs_a.e_PC), .e_IR(obs_a.e_IR), .e_Y(obs_a.e_Y),
        .e_Z(obs_a.e_Z), .e_MAR(obs_a.e_MAR), .e_MDR(obs_a.e_MDR),
        .MDR_read(obs_a.MDR_read), .ram_read(obs_a.ram_read), .Gra(obs_a.Gra),
        .e_Rout(obs_a.e_Rout), .imm_sel(obs_a.imm_sel), .ALU_op(obs_a.alu),
        .BusDataSelect(obs_a.bds), .busy(obs_a.busy), .done(obs_a.done), .taken(taken_a)
    );

    branch_seq #(.DATA_W(DW), .MEM_WAIT(3)) dut_b (
        .clock(clock), .clear(clear), .start(start), .ir_cond(ir_cond), .bus_in(bus_in),
        .incPC(obs_b.incPC), .e_PC(obs_b.e_PC), .e_IR(obs_b.e_IR), .e_Y(obs_b.e_Y),
        .e_Z(obs_b.e_Z), .e_MAR(obs_b.e_MAR), .e_MDR(obs_b.e_MDR),
        .MDR_read(obs_b.MDR_read), .ram_read(obs_b.ram_read), .Gra(obs_b.Gra),
        .e_Rout(obs_b.e_Rout), .imm_sel(obs_b.imm_sel), .ALU_op(obs_b.alu),
        .BusDataSelect(obs_b.bds), .busy(obs_b.busy), .done(obs_b.done), .taken(taken_b)
    );

    // Reference model: per instance, a queue of expected control words, front
    // entry = current cycle; empty queue = idle.
    ent_t q[2][$];
    bit   tk[2];
    int   mw[2] = '{1, 3};
    int   total = 0;
    int   bad   = 0;

    function automatic bit branch_taken(logic [1:0] c, logic [DW-1:0] v);
        case (c)
            2'd0:    return v == 0;
            2'd1:    return v != 0;
            2'd2:    return $signed(v) >= 0;
            default: return $signed(v) < 0;
        endcase
    endfunction

    function automatic logic [DW-1:0] pick_bus();
        logic [DW-1:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return r | 32'h8000_0000;
            2:       return r & 32'h7fff_ffff;
            default: return r;
        endcase
    endfunction

    task automatic push_fetch(input int i);
        ctl_t c;
        c = '0; c.busy = 1; c.bds = 5'b10100; c.e_MAR = 1; c.incPC = 1; c.e_Z = 1;
        q[i].push_back('{c, 1'b0});
        for (int n = 0; n < mw[i]; n++) begin
            c = '0; c.busy = 1; c.ram_read = 1; c.bds = 5'b10011;
            q[i].push_back('{c, 1'b0});
        end
        c = '0; c.busy = 1; c.MDR_read = 1; c.e_MDR = 1;
        q[i].push_back('{c, 1'b0});
        c = '0; c.busy = 1; c.bds = 5'b10101; c.e_IR = 1;
        q[i].push_back('{c, 1'b0});
        c = '0; c.busy = 1; c.Gra = 1; c.e_Rout = 1;
        q[i].push_back('{c, 1'b1});
    endtask

    task automatic push_execute(input int i, input bit t);
        ctl_t c;
        if (!(SKIP && !t)) begin
            c = '0; c.busy = 1; c.bds = 5'b10100; c.e_Y = 1;
            q[i].push_back('{c, 1'b0});
            c = '0; c.busy = 1; c.bds = 5'b01100; c.imm_sel = 1; c.alu = 4'b0011; c.e_Z = 1;
            q[i].push_back('{c, 1'b0});
            c = '0; c.busy = 1; c.bds = 5'b10011; c.e_PC = t;
            q[i].push_back('{c, 1'b0});
        end
        c = '0; c.busy = 1; c.done = 1;
        q[i].push_back('{c, 1'b0});
    endtask

    task automatic check();
        ctl_t exp_c, got_c;
        logic got_t;
        for (int i = 0; i < 2; i++) begin
            exp_c = (q[i].size() != 0) ? q[i][0].c : '0;
            got_c = (i == 0) ? obs_a : obs_b;
            got_t = (i == 0) ? taken_a : taken_b;
            total++;
            assert (got_c === exp_c) else begin
                bad++;
                $error("FAIL ctl[mw=%0d] t=%0t observed=%h expected=%h", mw[i], $time, got_c, exp_c);
            end
            total++;
            assert (got_t === tk[i]) else begin
                bad++;
                $error("FAIL taken[mw=%0d] t=%0t observed=%b expected=%b", mw[i], $time, got_t, tk[i]);
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic step();
        ent_t e;
        @(posedge clock);
        if (clear) begin
            for (int i = 0; i < 2; i++) begin
                if (q[i].size() == 0) begin
                    if (start) push_fetch(i);
                end else begin
                    e = q[i].pop_front();
                    if (e.t3) begin
                        tk[i] = branch_taken(ir_cond, bus_in);
                        push_execute(i, tk[i]);
                    end
                end
            end
        end
        #1;
        check();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < limit) begin
            step();
            n++;
        end
        total++;
        assert (q[0].size() == 0 && q[1].size() == 0) else begin
            bad++;
            $error("FAIL drain_timeout observed=%0d cycles expected<%0d", n, limit);
        end
    endtask

    task automatic launch(input logic [1:0] c, input logic [DW-1:0] v);
        ir_cond = c;
        bus_in  = v;
        start   = 1'b1;
        step();
        start   = 1'b0;
        drain(40);
    endtask

    task automatic apply_reset();
        clear = 1'b0;
        #1;
        q[0].delete();
        q[1].delete();
        tk[0] = 1'b0;
        tk[1] = 1'b0;
        check();
    endtask

    initial begin
        int n;
        clear   = 1'b0;
        start   = 1'b0;
        ir_cond = 2'd0;
        bus_in  = '0;
        tk[0]   = 1'b0;
        tk[1]   = 1'b0;
        #2;
        check();
        step();
        step();
        clear = 1'b1;
        step();

        // Directed branch cases.
        launch(2'd1, 32'h0000_0005);   // brnz, taken
        launch(2'd1, 32'h0000_0000);   // brnz, not taken
        launch(2'd3, 32'h8000_0000);   // brmi, taken
        launch(2'd2, 32'h8000_0000);   // brpl, not taken
        launch(2'd0, 32'h0000_0000);   // brzr, taken

        // start pulsed during T2 and during DONE must be ignored.
        ir_cond = 2'd2;
        bus_in  = 32'h0000_0005;
        start   = 1'b1;
        step();
        start   = 1'b0;
        step();
        step();
        step();
        start   = 1'b1;
        step();
        start   = 1'b0;
        n = 0;
        while (!(q[0].size() == 1 && q[0][0].c.done) && n < 20) begin
            step();
            n++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        drain(40);

        // Continuous start with the bus changing every cycle.
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ir_cond = 2'($urandom_range(0, 3));
            bus_in  = pick_bus();
            step();
        end
        start = 1'b0;
        drain(40);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            start   = ($urandom_range(0, 3) == 0);
            ir_cond = 2'($urandom_range(0, 3));
            bus_in  = pick_bus();
            step();
        end
        start = 1'b0;
        drain(40);

        // Reset asserted while the MEM_WAIT=1 instance sits in T5.
        launch(2'd1, 32'h0000_0007);       // leaves taken=1 beforehand
        ir_cond = 2'd1;
        bus_in  = 32'h0000_0009;
        start   = 1'b1;
        step();
        start   = 1'b0;
        n = 0;
        while (!(q[0].size() != 0 && q[0][0].c.imm_sel) && n < 20) begin
            step();
            n++;
        end
        apply_reset();
        step();
        step();
        clear = 1'b1;
        for (int k = 0; k < 3; k++) step();
        launch(2'd0, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
